// File: rtl/back_pressure_gen.sv
// Sink-side back-pressure generator: drives per-lane tready from an always/never/periodic/random
// pattern with a starvation guard, and counts accepted beats and stall cycles per lane.
module back_pressure_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PH_W   = 8
) (
    input  logic                    aclk,
    input  logic                    arstn,
    input  logic                    cfg_en,
    input  logic [1:0]              cfg_mode,
    input  logic [PH_W-1:0]         cfg_on_len,
    input  logic [PH_W-1:0]         cfg_off_len,
    input  logic [7:0]              cfg_rand_thr,
    input  logic [15:0]             cfg_seed,
    input  logic [PH_W-1:0]         cfg_max_stall,
    input  logic                    cnt_clr,
    input  logic [NUM_CH-1:0]       tvalid,
    output logic [NUM_CH-1:0]       tready,
    output logic [NUM_CH*CNT_W-1:0] beat_cnt,
    output logic [NUM_CH*CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_e;

    localparam logic [PH_W-1:0]  ONE_PH  = {{(PH_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [15:0] lane_seed(input logic [15:0] seed, input int idx);
        logic [15:0] s;
        s = seed ^ (16'(idx) * 16'h1111);
        return (s == 16'h0000) ? 16'hACE1 : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        phase_e           ph_q, ph_d;
        logic [PH_W-1:0]  phc_q, phc_d;
        logic [15:0]      lfsr_q, lfsr_d;
        logic             loaded_q, loaded_d;
        logic [PH_W-1:0]  run_q, run_d;
        logic             rdy_q, rdy_d;
        logic [CNT_W-1:0] beat_q, beat_d;
        logic [CNT_W-1:0] stall_q, stall_d;
        logic [15:0]      seed_s, lfsr_cur_s;
        logic             pat_s, guard_s, beat_ev_s, stall_ev_s;

        // Until the first enabled cycle the LFSR reads as the live lane seed.
        assign seed_s     = lane_seed(cfg_seed, g);
        assign lfsr_cur_s = loaded_q ? lfsr_q : seed_s;
        assign beat_ev_s  = tvalid[g] & rdy_q;
        assign stall_ev_s = tvalid[g] & ~rdy_q;

        // Pattern selection and periodic phase FSM next state
        always_comb begin
            pat_s = 1'b0;
            ph_d  = PH_ON;
            phc_d = '0;
            if (cfg_en) begin
                case (cfg_mode)
                    2'd0: pat_s = 1'b1;
                    2'd1: pat_s = 1'b0;
                    2'd2: begin
                        if (cfg_on_len == '0) begin
                            pat_s = 1'b0;
                            ph_d  = PH_OFF;
                        end else if (cfg_off_len == '0) begin
                            pat_s = 1'b1;
                            ph_d  = PH_ON;
                        end else if (ph_q == PH_ON) begin
                            pat_s = 1'b1;
                            if (phc_q >= cfg_on_len - ONE_PH) begin
                                ph_d  = PH_OFF;
                                phc_d = '0;
                            end else begin
                                ph_d  = PH_ON;
                                phc_d = phc_q + ONE_PH;
                            end
                        end else begin
                            pat_s = 1'b0;
                            if (phc_q >= cfg_off_len - ONE_PH) begin
                                ph_d  = PH_ON;
                                phc_d = '0;
                            end else begin
                                ph_d  = PH_OFF;
                                phc_d = phc_q + ONE_PH;
                            end
                        end
                    end
                    2'd3: pat_s = (lfsr_cur_s[7:0] < cfg_rand_thr);
                    default: pat_s = 1'b0;
                endcase
            end else begin
                pat_s = 1'b0;
                ph_d  = PH_ON;
                phc_d = '0;
            end
        end

        // LFSR advance, stall run, guard, ready and counter next state
        always_comb begin
            loaded_d = loaded_q;
            lfsr_d   = lfsr_q;
            run_d    = '0;
            beat_d   = beat_q;
            stall_d  = stall_q;
            if (cfg_en) begin
                loaded_d = 1'b1;
                lfsr_d   = (cfg_mode == 2'd3) ? lfsr_step(lfsr_cur_s) : lfsr_cur_s;
                if (stall_ev_s) begin
                    run_d = (run_q == {PH_W{1'b1}}) ? run_q : run_q + ONE_PH;
                end else begin
                    run_d = '0;
                end
            end else begin
                loaded_d = 1'b0;
                lfsr_d   = seed_s;
                run_d    = '0;
            end
            guard_s = (cfg_max_stall != '0) && (run_d >= cfg_max_stall);
            rdy_d   = cfg_en && (pat_s || guard_s);
            if (cnt_clr) begin
                beat_d  = '0;
                stall_d = '0;
            end else if (cfg_en) begin
                beat_d  = (beat_ev_s && beat_q != {CNT_W{1'b1}}) ? beat_q + ONE_CNT : beat_q;
                stall_d = (stall_ev_s && stall_q != {CNT_W{1'b1}}) ? stall_q + ONE_CNT : stall_q;
            end else begin
                beat_d  = beat_q;
                stall_d = stall_q;
            end
        end

        // Lane state registers
        always_ff @(posedge aclk or negedge arstn) begin
            if (!arstn) begin
                ph_q     <= PH_ON;
                phc_q    <= '0;
                lfsr_q   <= 16'h0000;
                loaded_q <= 1'b0;
                run_q    <= '0;
                rdy_q    <= 1'b0;
                beat_q   <= '0;
                stall_q  <= '0;
            end else begin
                ph_q     <= ph_d;
                phc_q    <= phc_d;
                lfsr_q   <= lfsr_d;
                loaded_q <= loaded_d;
                run_q    <= run_d;
                rdy_q    <= rdy_d;
                beat_q   <= beat_d;
                stall_q  <= stall_d;
            end
        end

        assign tready[g]                     = rdy_q;
        assign beat_cnt[g*CNT_W +: CNT_W]    = beat_q;
        assign stall_cnt[g*CNT_W +: CNT_W]   = stall_q;
    end

endmodule

// File: tb/tb_back_pressure_gen.sv
// Bench for back_pressure_gen: directed scenarios plus randomized segments against a
// cycle-level reference model (modulo-period pattern, spec-level LFSR, plain integer counters).
module tb_back_pressure_gen;
    localparam int N = 4;

    logic        aclk = 1'b0;
    logic        arstn;
    logic        cfg_en;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_on_len, cfg_off_len, cfg_rand_thr, cfg_max_stall;
    logic [15:0] cfg_seed;
    logic        cnt_clr;
    logic [3:0]  tvalid;
    logic [3:0]  tready, tready_s;
    logic [63:0] beat_cnt, stall_cnt;
    logic [15:0] beat_s, stall_s;

    back_pressure_gen #(.NUM_CH(4), .CNT_W(16), .PH_W(8)) dut (
        .aclk(aclk), .arstn(arstn), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_on_len(cfg_on_len), .cfg_off_len(cfg_off_len), .cfg_rand_thr(cfg_rand_thr),
        .cfg_seed(cfg_seed), .cfg_max_stall(cfg_max_stall), .cnt_clr(cnt_clr),
        .tvalid(tvalid), .tready(tready), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt));

    back_pressure_gen #(.NUM_CH(4), .CNT_W(4), .PH_W(8)) dut_s (
        .aclk(aclk), .arstn(arstn), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_on_len(cfg_on_len), .cfg_off_len(cfg_off_len), .cfg_rand_thr(cfg_rand_thr),
        .cfg_seed(cfg_seed), .cfg_max_stall(cfg_max_stall), .cnt_clr(cnt_clr),
        .tvalid(tvalid), .tready(tready_s), .beat_cnt(beat_s), .stall_cnt(stall_s));

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] lane_ofs [N] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333};
    bit          m_rdy   [N];
    int          m_beat  [N];
    int          m_stall [N];
    int          m_run   [N];
    logic [15:0] m_lfsr  [N];
    int          m_k;

    function automatic logic [15:0] seed_of(input logic [15:0] s, input int i);
        logic [15:0] v;
        v = s ^ lane_ofs[i];
        if (v == 16'h0000) v = 16'hACE1;
        return v;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_rdy[i] = 1'b0; m_beat[i] = 0; m_stall[i] = 0; m_run[i] = 0;
            m_lfsr[i] = seed_of(cfg_seed, i);
        end
        m_k = 0;
    endtask

    task automatic compare_all(input string pfx);
        logic [3:0]  er;
        logic [63:0] eb, es;
        logic [15:0] ebs, ess;
        for (int i = 0; i < N; i++) begin
            er[i]          = m_rdy[i];
            eb[i*16 +: 16] = 16'(sat(m_beat[i], 65535));
            es[i*16 +: 16] = 16'(sat(m_stall[i], 65535));
            ebs[i*4 +: 4]  = 4'(sat(m_beat[i], 15));
            ess[i*4 +: 4]  = 4'(sat(m_stall[i], 15));
        end
        check({pfx, "_tready"}, tready, er);
        check({pfx, "_tready_s"}, tready_s, er);
        check({pfx, "_beat"}, beat_cnt, eb);
        check({pfx, "_stall"}, stall_cnt, es);
        check({pfx, "_beat_s"}, beat_s, ebs);
        check({pfx, "_stall_s"}, stall_s, ess);
    endtask

    // One clock: advance model from current inputs, clock DUT, compare
    task automatic step();
        bit nxt [N];
        bit pat, guard;
        int run_n, per;
        for (int i = 0; i < N; i++) begin
            case (cfg_mode)
                2'd0: pat = 1'b1;
                2'd1: pat = 1'b0;
                2'd2: begin
                    per = int'(cfg_on_len) + int'(cfg_off_len);
                    if (cfg_on_len == 8'd0)       pat = 1'b0;
                    else if (cfg_off_len == 8'd0) pat = 1'b1;
                    else                          pat = (m_k % per) < int'(cfg_on_len);
                end
                default: pat = (m_lfsr[i][7:0] < cfg_rand_thr);
            endcase
            run_n = (cfg_en && tvalid[i] && !m_rdy[i]) ? sat(m_run[i] + 1, 255) : 0;
            guard = (cfg_max_stall != 8'd0) && (run_n >= int'(cfg_max_stall));
            nxt[i] = cfg_en && (pat || guard);
            if (cnt_clr) begin
                m_beat[i] = 0; m_stall[i] = 0;
            end else if (cfg_en) begin
                if (tvalid[i] && m_rdy[i])  m_beat[i]++;
                if (tvalid[i] && !m_rdy[i]) m_stall[i]++;
            end
            m_run[i] = run_n;
            if (!cfg_en) m_lfsr[i] = seed_of(cfg_seed, i);
            else if (cfg_mode == 2'd3)
                m_lfsr[i] = m_lfsr[i][0] ? ((m_lfsr[i] >> 1) ^ 16'hB400) : (m_lfsr[i] >> 1);
        end
        m_k = (cfg_en && cfg_mode == 2'd2) ? m_k + 1 : 0;
        for (int i = 0; i < N; i++) m_rdy[i] = nxt[i];
        @(posedge aclk);
        #1;
        compare_all("cyc");
    endtask

    task automatic quiesce_clear();
        cfg_en = 1'b0; tvalid = 4'h0; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    int ones;

    initial begin
        arstn = 1'b0; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_on_len = 8'd3; cfg_off_len = 8'd2;
        cfg_rand_thr = 8'd128; cfg_max_stall = 8'd0; cfg_seed = 16'h0000; cnt_clr = 1'b0;
        tvalid = 4'h0;
        model_reset();
        #12;
        compare_all("reset");
        arstn = 1'b1;

        // Always ready, then saturation of the narrow counters and clear priority
        cfg_en = 1'b1; cfg_mode = 2'd0;
        step();
        tvalid = 4'hF;
        repeat (10) step();
        check("m0_beat", beat_cnt, {4{16'd10}});
        check("m0_stall", stall_cnt, 64'd0);
        check("m0_beat_s", beat_s, {4{4'd10}});
        repeat (10) step();
        check("sat_beat_s", beat_s, {4{4'hF}});
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_beat", beat_cnt, 64'd0);
        check("clr_beat_s", beat_s, 16'd0);

        // Periodic 3 on / 2 off
        quiesce_clear();
        cfg_en = 1'b1; cfg_mode = 2'd2; cfg_on_len = 8'd3; cfg_off_len = 8'd2;
        step();
        tvalid = 4'hF;
        repeat (20) step();
        check("per_beat", beat_cnt, {4{16'd12}});
        check("per_stall", stall_cnt, {4{16'd8}});

        // Never ready with starvation guard on lane 0
        quiesce_clear();
        cfg_en = 1'b1; cfg_mode = 2'd1; cfg_max_stall = 8'd4; tvalid = 4'b0001;
        ones = 0;
        repeat (20) begin
            step();
            ones += int'(tready[0]);
        end
        check("guard_ones", 64'(ones), 64'd4);
        check("guard_beat0", beat_cnt[15:0], 16'd4);
        check("guard_stall0", stall_cnt[15:0], 16'd16);
        check("guard_other", {beat_cnt[63:16], stall_cnt[63:16]}, 96'd0);

        // Random mode from seed 0 (lane 0 uses ACE1)
        cfg_seed = 16'h0000;
        quiesce_clear();
        cfg_en = 1'b1; cfg_mode = 2'd3; cfg_rand_thr = 8'd128; cfg_max_stall = 8'd0;
        ones = 0;
        repeat (1000) begin
            tvalid = 4'($urandom);
            step();
            ones += int'(tready[0]);
        end
        check("rnd_ratio", 64'((ones >= 400) && (ones <= 600)), 64'd1);
        cfg_rand_thr = 8'd0;
        repeat (50) begin
            tvalid = 4'($urandom);
            step();
        end
        check("rnd_thr0", tready, 4'h0);

        // Asynchronous reset in the middle of an OFF phase
        quiesce_clear();
        cfg_en = 1'b1; cfg_mode = 2'd2; cfg_on_len = 8'd3; cfg_off_len = 8'd2; tvalid = 4'hF;
        repeat (4) step();
        #2 arstn = 1'b0;
        #1;
        model_reset();
        compare_all("arst");
        #2 arstn = 1'b1;
        step();
        check("arst_first_on", tready, 4'hF);

        // Randomized configuration segments
        repeat (12) begin
            cfg_en = 1'b0; cnt_clr = 1'($urandom_range(0, 1));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_on_len = 8'($urandom_range(0, 6)); cfg_off_len = 8'($urandom_range(0, 6));
            cfg_rand_thr = 8'($urandom); cfg_max_stall = 8'($urandom_range(0, 6));
            cfg_seed = 16'($urandom); tvalid = 4'($urandom);
            step();
            cfg_en = 1'b1;
            repeat (150) begin
                tvalid  = 4'($urandom);
                cnt_clr = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 39) == 0) cfg_mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) cfg_max_stall = 8'($urandom_range(0, 6));
                if ($urandom_range(0, 39) == 0) cfg_rand_thr = 8'($urandom);
                cfg_en = ($urandom_range(0, 49) != 0);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
